adc_digout_deser: RTL and testbench
===================================

# adc_digout_deser

Receive-side deserializer and checker for the sensor ADC serial output bus DIGOUT[17:1]. Per row, it captures 12 bits LSB-first on every lane, one bit per ADC_DATA_VALID pulse, and presents the 17 assembled words. It also checks the words against the incrementing row-address test pattern that the DIGOUT test generator drives, so the board can self-check the readout path on the same clock without the sensor attached.

## Interface
- NBITS, 12, bits per lane per row
- NLANES, 17, number of DIGOUT lanes
- TIMEOUT, 1024, max clk cycles between ADC_DATA_VALID rising edges inside a row before abort
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- RST_BAR_LTCHD  input  1  row start; active low (level)
- ADC_DATA_VALID  input  1  bit strobe; one high pulse per bit
- DIGOUT  input  [17:1]  serial data lanes; stable while ADC_DATA_VALID high
- word_valid  output  1  one-cycle pulse, row word complete
- word_data  output  NLANES*NBITS  lane k (1-based) at [(k-1)*NBITS +: NBITS]; held until next word_valid
- lane_mismatch  output  1  qualified by word_valid: some lane differs from lane 1
- value_mismatch  output  1  qualified by word_valid: lane 1 differs from expected row
- err_flag  output  1  sticky; set by any mismatch or timeout
- err_count  output  16  saturating count of words with any mismatch
- word_count  output  32  completed words, wraps at 2^32
- timeout_flag  output  1  sticky; row aborted by timeout

## Operation
- Input stage: RST_BAR_LTCHD, ADC_DATA_VALID and DIGOUT registered once together (_q). ADC_DATA_VALID also delayed once more (_qq). Bit edge = valid_q & ~valid_qq.
- FSM states: S_IDLE, S_SHIFT.
- S_IDLE: clear bit counter and timeout counter. If RST_BAR_LTCHD_q == 0 -> S_SHIFT. Bit edges in S_IDLE are ignored.
- S_SHIFT: on a bit edge, each lane shift register <= {DIGOUT_q[k], sr[NBITS-1:1]} (LSB-first), and the bit counter increments.
  - On the NBITS-th edge: load word_data with the shifted values, pulse word_valid, run the checks, then -> S_IDLE.
  - RST_BAR_LTCHD transitions in S_SHIFT are ignored (no restart).
- Timeout counter: increments each S_SHIFT cycle without a bit edge and clears on a bit edge. When it reaches TIMEOUT-1: set timeout_flag and err_flag, discard the partial word, -> S_IDLE. No word_valid.
- Checks, at word_valid:
  - lane_mismatch = any lane word != lane 1 word.
  - value_mismatch = lane 1 word != expected[NBITS-1:0].
  - expected resets to 0. After each word, expected <= lane 1 word + 1, mod 2^NBITS (resync, so one dropped row yields a single error).
  - err_count += 1 if either mismatch; saturates at 16'hFFFF.
  - err_flag set if either mismatch.
- Reset values: word_valid 0, word_data 0, lane_mismatch 0, value_mismatch 0, err_flag 0, err_count 0, word_count 0, timeout_flag 0, expected 0, shift regs 0, state S_IDLE.
- rst mid-row: abandons the row immediately; all state returns to reset values; no word_valid.

## Timing
- ADC_DATA_VALID first sampled high at edge t: the bit shifts at edge t+1, using DIGOUT sampled at edge t.
- For the final bit, word_valid and the check outputs are high for the cycle following edge t+1.
- Minimum ADC_DATA_VALID low time between bits: 1 cycle. Minimum high time: 1 cycle.
- S_IDLE to S_SHIFT entry: 1 cycle after RST_BAR_LTCHD_q low. A bit edge in the entry cycle is not captured, so the generator must not assert ADC_DATA_VALID within 2 cycles of RST_BAR_LTCHD falling.
- lane_mismatch and value_mismatch: 0 when word_valid is 0.

## Test plan
- Generator drives rows 0,1,2 -> three word_valid pulses; all lanes 12'h000, 12'h001, 12'h002; err_flag 0; word_count 3.
- Lane 5 forced 0 during row 3 (value 12'h003) -> word_valid with lane_mismatch 1, value_mismatch 0; err_count 1; err_flag 1.
- Rows 0..4, then 6 (row 5 skipped), then 7 -> value_mismatch on row 6 only; err_count 1; row 7 clean.
- Row stalls after 4 ADC_DATA_VALID pulses -> timeout_flag 1 at TIMEOUT cycles; no word_valid; next full row 12'h00A captured cleanly.
- rst pulsed after bit 7 of a row -> all outputs return to reset values; next row captured correctly with expected 0.
- Rows 4094, 4095, 0 (expected preloaded via resync on 4094) -> 4094 flags value_mismatch once; 4095 and 0 are clean, with wrap and no error.

Source files
------------

// File: rtl/adc_digout_if.sv
// Bundle of the DIGOUT receive bus and the assembled-word results of the deserializer.
// The generator side (master) drives the row/bit strobes and lanes; the deserializer (slave) returns words.
interface adc_digout_if #(
    parameter int NBITS  = 12,
    parameter int NLANES = 17
) ();
    logic                      RST_BAR_LTCHD;
    logic                      ADC_DATA_VALID;
    logic [NLANES:1]           DIGOUT;
    logic                      word_valid;
    logic [NLANES*NBITS-1:0]   word_data;
    logic                      lane_mismatch;
    logic                      value_mismatch;
    logic                      err_flag;
    logic [15:0]               err_count;
    logic [31:0]               word_count;
    logic                      timeout_flag;

    modport master (
        output RST_BAR_LTCHD, ADC_DATA_VALID, DIGOUT,
        input  word_valid, word_data, lane_mismatch, value_mismatch,
               err_flag, err_count, word_count, timeout_flag
    );

    modport slave (
        input  RST_BAR_LTCHD, ADC_DATA_VALID, DIGOUT,
        output word_valid, word_data, lane_mismatch, value_mismatch,
               err_flag, err_count, word_count, timeout_flag
    );
endinterface

// File: rtl/adc_digout_deser.sv
// DIGOUT deserializer: assembles NBITS LSB-first bits per lane per row and checks the
// words against the incrementing row-address test pattern, with a per-bit stall timeout.
module adc_digout_deser #(
    parameter int NBITS   = 12,
    parameter int NLANES  = 17,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    adc_digout_if.slave     bus
);
    localparam int WW = NLANES * NBITS;
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t                 state_q, state_d;
    logic                   rst_bar_q;
    logic                   valid_q, valid_qq;
    logic [NLANES:1]        digout_q;
    logic [BW-1:0]          bcnt_q, bcnt_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [WW-1:0]          sr_q, sr_d;
    logic [WW-1:0]          sr_shift;
    logic [NLANES-1:0]      lane_diff;
    logic                   word_valid_q, word_valid_d;
    logic [WW-1:0]          word_data_q, word_data_d;
    logic                   lane_mm_q, lane_mm_d;
    logic                   value_mm_q, value_mm_d;
    logic                   err_flag_q, err_flag_d;
    logic [15:0]            err_count_q, err_count_d;
    logic [31:0]            word_count_q, word_count_d;
    logic                   timeout_q, timeout_d;
    logic [NBITS-1:0]       expected_q, expected_d;
    logic                   bit_edge;
    logic [NBITS-1:0]       lane1;

    assign bit_edge = valid_q & ~valid_qq;
    assign lane1    = sr_shift[NBITS-1:0];

    // Each lane shifts its new bit in at the MSB so the first bit ends up at bit 0.
    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            assign sr_shift[gi*NBITS +: NBITS] =
                {digout_q[gi+1], sr_q[gi*NBITS+1 +: NBITS-1]};
            assign lane_diff[gi] = (sr_shift[gi*NBITS +: NBITS] != lane1);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        tcnt_d       = tcnt_q;
        sr_d         = sr_q;
        word_valid_d = 1'b0;
        word_data_d  = word_data_q;
        lane_mm_d    = 1'b0;
        value_mm_d   = 1'b0;
        err_flag_d   = err_flag_q;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
        timeout_d    = timeout_q;
        expected_d   = expected_q;
        case (state_q)
            S_IDLE: begin
                bcnt_d = '0;
                tcnt_d = '0;
                if (!rst_bar_q) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_edge) begin
                    sr_d   = sr_shift;
                    tcnt_d = '0;
                    if (bcnt_q == BW'(NBITS-1)) begin
                        word_valid_d = 1'b1;
                        word_data_d  = sr_shift;
                        lane_mm_d    = |lane_diff;
                        value_mm_d   = (lane1 != expected_q);
                        // Resync to the received row so a dropped row costs one error.
                        expected_d   = lane1 + NBITS'(1);
                        word_count_d = word_count_q + 32'd1;
                        if (lane_mm_d || value_mm_d) begin
                            err_flag_d = 1'b1;
                            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                        end
                        bcnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end else if (tcnt_q == TW'(TIMEOUT-1)) begin
                    timeout_d  = 1'b1;
                    err_flag_d = 1'b1;
                    bcnt_d     = '0;
                    tcnt_d     = '0;
                    state_d    = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rst_bar_q    <= 1'b1;
            valid_q      <= 1'b0;
            valid_qq     <= 1'b0;
            digout_q     <= '0;
            bcnt_q       <= '0;
            tcnt_q       <= '0;
            sr_q         <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            lane_mm_q    <= 1'b0;
            value_mm_q   <= 1'b0;
            err_flag_q   <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
            timeout_q    <= 1'b0;
            expected_q   <= '0;
        end else begin
            state_q      <= state_d;
            rst_bar_q    <= bus.RST_BAR_LTCHD;
            valid_q      <= bus.ADC_DATA_VALID;
            valid_qq     <= valid_q;
            digout_q     <= bus.DIGOUT;
            bcnt_q       <= bcnt_d;
            tcnt_q       <= tcnt_d;
            sr_q         <= sr_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            lane_mm_q    <= lane_mm_d;
            value_mm_q   <= value_mm_d;
            err_flag_q   <= err_flag_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
            timeout_q    <= timeout_d;
            expected_q   <= expected_d;
        end
    end

    assign bus.word_valid     = word_valid_q;
    assign bus.word_data      = word_data_q;
    assign bus.lane_mismatch  = lane_mm_q;
    assign bus.value_mismatch = value_mm_q;
    assign bus.err_flag       = err_flag_q;
    assign bus.err_count      = err_count_q;
    assign bus.word_count     = word_count_q;
    assign bus.timeout_flag   = timeout_q;
endmodule

// File: tb/tb_adc_digout_deser.sv
// Self-checking bench for adc_digout_deser: table of pattern rows, stall/reset corner
// sequences, and random rows checked against a row-level reference model.
module tb_adc_digout_deser;
    localparam int NBITS   = 12;
    localparam int NLANES  = 17;
    localparam int TIMEOUT = 1024;

    typedef logic [NBITS-1:0] lanes_t [NLANES];
    typedef struct {
        logic [NLANES*NBITS-1:0] data;
        logic                    lm;
        logic                    vm;
    } word_rec_t;
    typedef struct {
        bit rst_before;
        int row;
        int bad_lane;
        int bad_val;
        bit exp_lm;
        bit exp_vm;
        int exp_ec;
        bit exp_ef;
        int exp_wc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    int   m_exp, m_ec, m_wc;
    bit   m_ef, m_to;
    word_rec_t wq[$];

    always #5 clk = ~clk;

    adc_digout_if #(.NBITS(NBITS), .NLANES(NLANES)) bus ();

    adc_digout_deser #(.NBITS(NBITS), .NLANES(NLANES), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Capture every word pulse; mismatch flags must stay low between pulses.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.word_valid === 1'b1) begin
                wq.push_back('{bus.word_data, bus.lane_mismatch, bus.value_mismatch});
            end else begin
                chk("flags_unqualified", {62'd0, bus.lane_mismatch, bus.value_mismatch}, 64'd0);
            end
        end
    end

    function automatic lanes_t make_row(input int val, input int bad_lane, input int bad_val);
        lanes_t v;
        for (int i = 0; i < NLANES; i++) v[i] = NBITS'(val);
        if (bad_lane > 0) v[bad_lane-1] = NBITS'(bad_val);
        return v;
    endfunction

    task automatic model_reset();
        m_exp = 0; m_ec = 0; m_wc = 0; m_ef = 0; m_to = 0;
    endtask

    task automatic model_word(input lanes_t v, output bit lm, output bit vm);
        lm = 0;
        for (int i = 1; i < NLANES; i++) if (v[i] != v[0]) lm = 1;
        vm = (int'(v[0]) != m_exp);
        if (lm || vm) begin
            m_ef = 1;
            if (m_ec < 65535) m_ec++;
        end
        m_wc++;
        m_exp = (int'(v[0]) + 1) % (1 << NBITS);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.RST_BAR_LTCHD  = 1'b1;
        bus.ADC_DATA_VALID = 1'b0;
        bus.DIGOUT         = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wq.delete();
        model_reset();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_word_valid"}, 64'(bus.word_valid), 64'd0);
        chk({tag, "_word_data_lo"}, bus.word_data[63:0], 64'd0);
        chk({tag, "_word_data_hi"}, 64'(bus.word_data[NLANES*NBITS-1:64]), 64'd0);
        chk({tag, "_lane_mm"}, 64'(bus.lane_mismatch), 64'd0);
        chk({tag, "_value_mm"}, 64'(bus.value_mismatch), 64'd0);
        chk({tag, "_err_flag"}, 64'(bus.err_flag), 64'd0);
        chk({tag, "_err_count"}, 64'(bus.err_count), 64'd0);
        chk({tag, "_word_count"}, 64'(bus.word_count), 64'd0);
        chk({tag, "_timeout"}, 64'(bus.timeout_flag), 64'd0);
    endtask

    // Start a row and clock out nb bits with random high/low strobe widths.
    task automatic send_bits(input lanes_t v, input int nb);
        @(negedge clk);
        bus.RST_BAR_LTCHD = 1'b0;
        @(negedge clk);
        bus.RST_BAR_LTCHD = 1'b1;
        repeat (2) @(negedge clk);
        for (int b = 0; b < nb; b++) begin
            for (int k = 1; k <= NLANES; k++) bus.DIGOUT[k] = v[k-1][b];
            bus.ADC_DATA_VALID = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            bus.ADC_DATA_VALID = 1'b0;
            bus.DIGOUT = NLANES'($urandom);
            if (b != nb - 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic wait_word(input string tag, output word_rec_t r, output bit got);
        got = 0;
        r = '{default: '0};
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            #1;
            if (wq.size() > 0) begin
                r = wq.pop_front();
                got = 1;
            end
        end
        chk({tag, "_word_arrived"}, 64'(got), 64'd1);
    endtask

    task automatic check_word(input string tag, input lanes_t v, input word_rec_t r,
                              input bit elm, input bit evm, input int eec, input bit eef,
                              input int ewc, input bit eto);
        int nbad = 0;
        for (int k = 0; k < NLANES; k++)
            if (r.data[k*NBITS +: NBITS] !== v[k]) nbad++;
        chk({tag, "_lanes_wrong"}, 64'(nbad), 64'd0);
        chk({tag, "_lane_mm"}, 64'(r.lm), 64'(elm));
        chk({tag, "_value_mm"}, 64'(r.vm), 64'(evm));
        chk({tag, "_err_count"}, 64'(bus.err_count), 64'(eec));
        chk({tag, "_err_flag"}, 64'(bus.err_flag), 64'(eef));
        chk({tag, "_word_count"}, 64'(bus.word_count), 64'(ewc));
        chk({tag, "_timeout"}, 64'(bus.timeout_flag), 64'(eto));
    endtask

    task automatic model_row(input string tag, input lanes_t v);
        word_rec_t r;
        bit got, lm, vm;
        send_bits(v, NBITS);
        wait_word(tag, r, got);
        model_word(v, lm, vm);
        if (got) check_word(tag, v, r, lm, vm, m_ec, m_ef, m_wc, m_to);
        $display("row %s lane1=%03h lm=%0b vm=%0b ec=%0d wc=%0d", tag, v[0], r.lm, r.vm,
                 bus.err_count, bus.word_count);
    endtask

    vec_t vecs[14];

    initial begin
        rst = 1'b1;
        bus.RST_BAR_LTCHD  = 1'b1;
        bus.ADC_DATA_VALID = 1'b0;
        bus.DIGOUT         = '0;
        //            rst row   lane val  lm vm ec ef wc
        vecs[0]  = '{1, 0,    0, 0,    0, 0, 0, 0, 1};
        vecs[1]  = '{0, 1,    0, 0,    0, 0, 0, 0, 2};
        vecs[2]  = '{0, 2,    0, 0,    0, 0, 0, 0, 3};
        vecs[3]  = '{0, 3,    5, 0,    1, 0, 1, 1, 4};
        vecs[4]  = '{1, 0,    0, 0,    0, 0, 0, 0, 1};
        vecs[5]  = '{0, 1,    0, 0,    0, 0, 0, 0, 2};
        vecs[6]  = '{0, 2,    0, 0,    0, 0, 0, 0, 3};
        vecs[7]  = '{0, 3,    0, 0,    0, 0, 0, 0, 4};
        vecs[8]  = '{0, 4,    0, 0,    0, 0, 0, 0, 5};
        vecs[9]  = '{0, 6,    0, 0,    0, 1, 1, 1, 6};
        vecs[10] = '{0, 7,    0, 0,    0, 0, 1, 1, 7};
        vecs[11] = '{1, 4094, 0, 0,    0, 1, 1, 1, 1};
        vecs[12] = '{0, 4095, 0, 0,    0, 0, 1, 1, 2};
        vecs[13] = '{0, 0,    0, 0,    0, 0, 1, 1, 3};

        do_reset();
        #1;
        check_reset_state("reset");

        for (int i = 0; i < 14; i++) begin
            lanes_t v;
            word_rec_t r;
            bit got, lm, vm;
            if (vecs[i].rst_before) do_reset();
            v = make_row(vecs[i].row, vecs[i].bad_lane, vecs[i].bad_val);
            send_bits(v, NBITS);
            wait_word($sformatf("vec%0d", i), r, got);
            model_word(v, lm, vm);
            if (got) check_word($sformatf("vec%0d", i), v, r, vecs[i].exp_lm, vecs[i].exp_vm,
                                vecs[i].exp_ec, vecs[i].exp_ef, vecs[i].exp_wc, 1'b0);
            $display("vec %0d row=%03h lm=%0b vm=%0b ec=%0d wc=%0d", i, vecs[i].row, r.lm, r.vm,
                     bus.err_count, bus.word_count);
        end

        // Stall after 4 bits: timeout, no word, next row still clean.
        do_reset();
        for (int i = 0; i < 10; i++) model_row($sformatf("pre%0d", i), make_row(i, 0, 0));
        begin
            int c;
            bit seen = 0;
            send_bits(make_row(12'h5A5, 0, 0), 4);
            for (c = 1; c <= TIMEOUT + 40; c++) begin
                @(negedge clk);
                if (bus.timeout_flag === 1'b1) begin
                    seen = 1;
                    break;
                end
            end
            chk("timeout_seen", 64'(seen), 64'd1);
            chk("timeout_window", 64'(c >= TIMEOUT - 8 && c <= TIMEOUT + 8), 64'd1);
            chk("timeout_err_flag", 64'(bus.err_flag), 64'd1);
            chk("timeout_no_word", 64'(wq.size()), 64'd0);
            $display("timeout after %0d cycles flag=%0b", c, bus.timeout_flag);
            m_to = 1;
            m_ef = 1;
        end
        model_row("after_timeout", make_row(12'h00A, 0, 0));

        // Reset in the middle of a row.
        do_reset();
        model_row("mid_pre", make_row(0, 0, 0));
        send_bits(make_row(12'h3C3, 0, 0), 7);
        do_reset();
        #1;
        check_reset_state("mid_rst");
        chk("mid_rst_no_word", 64'(wq.size()), 64'd0);
        model_row("mid_post", make_row(0, 0, 0));

        // Random rows against the model.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int val, bl, bv;
            val = ($urandom_range(0, 9) < 7) ? m_exp : int'($urandom_range(0, 4095));
            bl  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, NLANES)) : 0;
            bv  = int'($urandom_range(0, 4095));
            model_row($sformatf("rnd%0d", i), make_row(val, bl, bv));
        end
        repeat (5) @(negedge clk);
        chk("no_extra_words", 64'(wq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end
endmodule
